// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and header constants for the packet ALU.
package alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA5;
  localparam logic [7:0] OP_MUL  = 8'hB1;
  localparam logic [7:0] OP_XOR  = 8'hC3;

  localparam int         HDR_BYTES = 4;
  localparam logic [7:0] ERR_BYTE  = 8'hEE;

  // Encodings are visible on state_o for LED debug, so they are fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RSV    = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_LEN_HI = 3'd3,
    ST_ECHO   = 3'd4,
    ST_ACCUM  = 3'd5,
    ST_SEND   = 3'd6,
    ST_DRAIN  = 3'd7
  } state_t;

  function automatic logic is_arith(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu_op_unit.sv
// Combinational reduction step: result = acc OP operand, wrapping to DATA_W bits.
module alu_op_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [7:0]        opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = acc;
    case (opcode)
      OP_ADD:  result = acc + operand;
      OP_MUL:  result = acc * operand;
      OP_XOR:  result = acc ^ operand;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/alu_packet_engine.sv
// Byte-stream packet ALU: parses a 4-byte header, reduces little-endian operands or echoes the packet.
// Optional error response byte is enabled with the ALU_ERR_RESP_EN macro.
module alu_packet_engine
  import alu_pkg::*;
#(
  parameter int OPERAND_BYTES = 4,
  parameter int LEN_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [2:0] state_o
);

  localparam int                DATA_W   = 8 * OPERAND_BYTES;
  localparam int                IDX_W    = 2;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(OPERAND_BYTES - 1);
  localparam logic [LEN_W-1:0]  HDR_LEN  = LEN_W'(HDR_BYTES);
  localparam logic [LEN_W-1:0]  OPB_LEN  = LEN_W'(OPERAND_BYTES);
  localparam logic [LEN_W-1:0]  ONE_LEN  = LEN_W'(1);
  localparam logic [2:0]        OPB_CNT  = 3'(OPERAND_BYTES);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_BYTE);

`ifdef ALU_ERR_RESP_EN
  localparam state_t ERR_NEXT = ST_SEND;
`else
  localparam state_t ERR_NEXT = ST_IDLE;
`endif

  state_t            state;
  logic [7:0]        opcode;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  remaining;
  logic [IDX_W-1:0]  byte_idx;
  logic              first_opnd;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] send_sh;
  logic [2:0]        send_len;
  logic [2:0]        send_cnt;

  logic              out_free;
  logic              echo_pkt;
  logic              accept;
  logic              fwd;
  logic              send_load;
  logic              send_done;
  logic [LEN_W-1:0]  len_full;
  logic [LEN_W-1:0]  rem_calc;
  logic              len_ok;
  logic [DATA_W-1:0] opnd_full;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] acc_next;

  assign state_o = state;

  always_comb begin
    out_free = !valid_o || ready_i;
    echo_pkt = (opcode == OP_ECHO);

    // Any state that may forward a byte must first have a free output slot.
    case (state)
      ST_IDLE:                      ready_o = out_free;
      ST_RSV, ST_LEN_LO, ST_LEN_HI: ready_o = echo_pkt ? out_free : 1'b1;
      ST_ECHO:                      ready_o = out_free;
      ST_ACCUM, ST_DRAIN:           ready_o = 1'b1;
      default:                      ready_o = 1'b0;
    endcase
    if (rst) ready_o = 1'b0;

    accept = valid_i && ready_o;

    // The opcode register still holds the previous packet while in IDLE.
    if (state == ST_IDLE)
      fwd = accept && (data_i == OP_ECHO);
    else
      fwd = accept && echo_pkt &&
            (state inside {ST_RSV, ST_LEN_LO, ST_LEN_HI, ST_ECHO});

    len_full = LEN_W'({data_i, len_lo});
    rem_calc = (len_full >= HDR_LEN) ? (len_full - HDR_LEN) : '0;
    len_ok   = (rem_calc >= OPB_LEN) && ((rem_calc % OPB_LEN) == '0);

    opnd_full = opnd;
    opnd_full[8*byte_idx +: 8] = data_i;
    acc_next  = first_opnd ? opnd_full : alu_result;

    send_load = (state == ST_SEND) && out_free && (send_cnt != send_len);
    send_done = (state == ST_SEND) && valid_o && ready_i && (send_cnt == send_len);
  end

  alu_op_unit #(
    .DATA_W (DATA_W)
  ) u_op (
    .opcode  (opcode),
    .acc     (acc),
    .operand (opnd_full),
    .result  (alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      opcode     <= '0;
      len_lo     <= '0;
      remaining  <= '0;
      byte_idx   <= '0;
      first_opnd <= 1'b1;
      opnd       <= '0;
      acc        <= '0;
      send_sh    <= '0;
      send_len   <= '0;
      send_cnt   <= '0;
      data_o     <= 8'h00;
      valid_o    <= 1'b0;
    end else begin
      if (fwd) begin
        data_o  <= data_i;
        valid_o <= 1'b1;
      end else if (send_load) begin
        data_o   <= send_sh[7:0];
        valid_o  <= 1'b1;
        send_sh  <= send_sh >> 8;
        send_cnt <= send_cnt + 3'd1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            opcode <= data_i;
            state  <= ST_RSV;
          end
        end
        ST_RSV: begin
          if (accept) state <= ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (accept) begin
            len_lo <= data_i;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            remaining  <= rem_calc;
            byte_idx   <= '0;
            first_opnd <= 1'b1;
            if (echo_pkt) begin
              state <= (rem_calc == '0) ? ST_IDLE : ST_ECHO;
            end else if (is_arith(opcode) && len_ok) begin
              state <= ST_ACCUM;
            end else if (rem_calc != '0) begin
              state <= ST_DRAIN;
            end else begin
              state    <= ERR_NEXT;
              send_sh  <= ERR_WORD;
              send_len <= 3'd1;
              send_cnt <= 3'd0;
            end
          end
        end
        ST_ECHO: begin
          if (accept) begin
            remaining <= remaining - ONE_LEN;
            if (remaining == ONE_LEN) state <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            remaining <= remaining - ONE_LEN;
            opnd      <= opnd_full;
            if (byte_idx == LAST_IDX) begin
              byte_idx   <= '0;
              first_opnd <= 1'b0;
              acc        <= acc_next;
              if (remaining == ONE_LEN) begin
                state    <= ST_SEND;
                send_sh  <= acc_next;
                send_len <= OPB_CNT;
                send_cnt <= 3'd0;
              end
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        ST_SEND: begin
          if (send_done) state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (accept) begin
            remaining <= remaining - ONE_LEN;
            if (remaining == ONE_LEN) begin
              state    <= ERR_NEXT;
              send_sh  <= ERR_WORD;
              send_len <= 3'd1;
              send_cnt <= 3'd0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_packet_engine.sv
// Directed bench for alu_packet_engine (OPERAND_BYTES=4); expected bytes are hand-computed.
module tb_alu_packet_engine;

`ifdef ALU_ERR_RESP_EN
  localparam int ERR_N = 1;
`else
  localparam int ERR_N = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [2:0] state_o;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] got [$];
  logic       chk_hold = 1'b0;
  logic       hold_prev = 1'b0;
  logic [7:0] dat_prev = 8'h00;
  logic       tog_en = 1'b0;
  logic       send_seen;
  logic       send_rdy;

  always #5 clk = ~clk;

  alu_packet_engine #(
    .OPERAND_BYTES (4),
    .LEN_W         (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .state_o (state_o)
  );

  // Inputs change 1 time unit after posedge, so values seen here hold at the next posedge.
  always @(negedge clk) begin
    if (chk_hold && hold_prev && !rst) begin
      n_vec++;
      if (valid_o !== 1'b1 || data_o !== dat_prev) begin
        n_err++;
        $display("FAIL hold_stable: valid_o=%b data_o=%02h, required valid_o=1 data_o=%02h",
                 valid_o, data_o, dat_prev);
      end
    end
    if (chk_hold && !rst && valid_o && !ready_i) begin
      n_vec++;
      if (ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL echo_ready_stall: ready_o=%b, required 0", ready_o);
      end
    end
    hold_prev = valid_o && !ready_i && !rst;
    dat_prev  = data_o;
    if (!rst && valid_o && ready_i) got.push_back(data_o);
  end

  task automatic send_byte(input logic [7:0] b);
    int   n = 0;
    logic done = 1'b0;
    data_i  = b;
    valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = ready_o;
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: byte %02h not accepted in %0d cycles, required acceptance", b, n);
        done = 1'b1;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] p [$]);
    foreach (p[i]) send_byte(p[i]);
  endtask

  // Waits (bounded) for n output bytes, then idles a few cycles so stray extra bytes show up.
  task automatic wait_out(input int n);
    int c = 0;
    send_seen = 1'b0;
    send_rdy  = 1'b0;
    while (got.size() < n && c < 300) begin
      @(negedge clk);
      if (state_o == 3'd6) begin
        send_seen = 1'b1;
        if (ready_o) send_rdy = 1'b1;
      end
      @(posedge clk); #1;
      c++;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_i = 1'b0; data_i = 8'h00; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: ready_o=%b, required 0", ready_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (state_o !== 3'd0 || valid_o !== 1'b0 || data_o !== 8'h00 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: state=%0d valid=%b data=%02h ready=%b, required 0 0 00 1",
               state_o, valid_o, data_o, ready_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    logic [7:0] pkt [$];
    logic [7:0] exp [4] = '{8'h06, 8'h00, 8'h00, 8'h00};
    logic [7:0] b;
    got.delete();
    pkt = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt);
    wait_out(4);
    n_vec++;
    if (got.size() !== 4) begin n_err++; $display("FAIL add_count: %0d bytes, required 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      b = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (b !== exp[i]) begin n_err++; $display("FAIL add_byte%0d: %02h, required %02h", i, b, exp[i]); end
    end
    n_vec++;
    if (!send_seen || send_rdy) begin
      n_err++;
      $display("FAIL add_send_ready: send_seen=%b ready_in_send=%b, required 1 0", send_seen, send_rdy);
    end
    n_vec++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL add_idle: state=%0d, required 0", state_o); end
  endtask

  task automatic test_mul;
    logic [7:0] pkt [$];
    logic [7:0] exp [4] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] b;
    got.delete();
    pkt = '{8'hB1, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt);
    wait_out(4);
    n_vec++;
    if (got.size() !== 4) begin n_err++; $display("FAIL mul_count: %0d bytes, required 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      b = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (b !== exp[i]) begin n_err++; $display("FAIL mul_byte%0d: %02h, required %02h", i, b, exp[i]); end
    end
  endtask

  task automatic test_xor;
    logic [7:0] pkt [$];
    logic [7:0] b;
    got.delete();
    pkt = '{8'hC3, 8'h00, 8'h0C, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F,
            8'hF0, 8'hF0, 8'hF0, 8'hF0};
    send_pkt(pkt);
    wait_out(4);
    n_vec++;
    if (got.size() !== 4) begin n_err++; $display("FAIL xor_count: %0d bytes, required 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      b = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (b !== 8'hFF) begin n_err++; $display("FAIL xor_byte%0d: %02h, required FF", i, b); end
    end
  endtask

  task automatic test_echo;
    logic [7:0] pkt [$];
    logic [7:0] b;
    got.delete();
    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    chk_hold = 1'b1;
    tog_en   = 1'b1;
    fork
      begin
        while (tog_en) begin
          @(posedge clk); #1;
          ready_i = ~ready_i;
        end
      end
    join_none
    send_pkt(pkt);
    wait_out(7);
    tog_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready_i  = 1'b1;
    chk_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (got.size() !== 7) begin n_err++; $display("FAIL echo_count: %0d bytes, required 7", got.size()); end
    for (int i = 0; i < 7; i++) begin
      b = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (b !== pkt[i]) begin n_err++; $display("FAIL echo_byte%0d: %02h, required %02h", i, b, pkt[i]); end
    end
    n_vec++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL echo_idle: state=%0d, required 0", state_o); end
  endtask

  task automatic test_echo_hdr_only;
    logic [7:0] pkt [$];
    logic [7:0] b;
    got.delete();
    pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
    send_pkt(pkt);
    wait_out(4);
    n_vec++;
    if (got.size() !== 4) begin n_err++; $display("FAIL echo4_count: %0d bytes, required 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      b = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (b !== pkt[i]) begin n_err++; $display("FAIL echo4_byte%0d: %02h, required %02h", i, b, pkt[i]); end
    end
    n_vec++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL echo4_idle: state=%0d, required 0", state_o); end
  endtask

  task automatic test_bad_len;
    logic [7:0] pkt [$];
    logic [7:0] exp [5] = '{8'hEE, 8'h05, 8'h00, 8'h00, 8'h00};
    logic [7:0] b;
    int         base;
    got.delete();
    pkt = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
    send_pkt(pkt);
    wait_out(ERR_N);
    n_vec++;
    if (got.size() !== ERR_N) begin n_err++; $display("FAIL badlen_count: %0d bytes, required %0d", got.size(), ERR_N); end
    n_vec++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL badlen_idle: state=%0d, required 0", state_o); end
    pkt = '{8'hA5, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt);
    wait_out(ERR_N + 4);
    n_vec++;
    if (got.size() !== ERR_N + 4) begin n_err++; $display("FAIL badlen_next_count: %0d bytes, required %0d", got.size(), ERR_N + 4); end
    base = 1 - ERR_N;
    for (int i = 0; i < ERR_N + 4; i++) begin
      b = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (b !== exp[base + i]) begin n_err++; $display("FAIL badlen_byte%0d: %02h, required %02h", i, b, exp[base + i]); end
    end
  endtask

  task automatic test_unknown_op;
    logic [7:0] pkt [$];
    logic [7:0] b;
    got.delete();
    pkt = '{8'h77, 8'h00, 8'h05, 8'h00, 8'h99};
    send_pkt(pkt);
    wait_out(ERR_N);
    n_vec++;
    if (got.size() !== ERR_N) begin n_err++; $display("FAIL unknown_count: %0d bytes, required %0d", got.size(), ERR_N); end
    for (int i = 0; i < ERR_N; i++) begin
      b = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (b !== 8'hEE) begin n_err++; $display("FAIL unknown_err_byte: %02h, required EE", b); end
    end
    n_vec++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL unknown_idle: state=%0d, required 0", state_o); end
  endtask

  task automatic test_short_len;
    logic [7:0] pkt [$];
    got.delete();
    pkt = '{8'hA5, 8'h00, 8'h02, 8'h00};
    send_pkt(pkt);
    wait_out(ERR_N);
    n_vec++;
    if (got.size() !== ERR_N) begin n_err++; $display("FAIL short_count: %0d bytes, required %0d", got.size(), ERR_N); end
    n_vec++;
    if (state_o !== 3'd0) begin n_err++; $display("FAIL short_idle: state=%0d, required 0", state_o); end
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ready_o !== 1'b0) begin n_err++; $display("FAIL %s_rst_ready: ready_o=%b, required 0", tag, ready_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (valid_o !== 1'b0 || state_o !== 3'd0) begin
      n_err++;
      $display("FAIL %s_rst_state: valid=%b state=%0d, required 0 0", tag, valid_o, state_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid_accum;
    logic [7:0] pkt [$];
    logic [7:0] exp [4] = '{8'h30, 8'h00, 8'h00, 8'h00};
    logic [7:0] b;
    pkt = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00};
    send_pkt(pkt);
    pulse_reset("accum");
    got.delete();
    pkt = '{8'hA5, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
            8'h20, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt);
    wait_out(4);
    n_vec++;
    if (got.size() !== 4) begin n_err++; $display("FAIL accum_rst_count: %0d bytes, required 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      b = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (b !== exp[i]) begin n_err++; $display("FAIL accum_rst_byte%0d: %02h, required %02h", i, b, exp[i]); end
    end
  endtask

  task automatic test_rst_mid_send;
    logic [7:0] pkt [$];
    logic [7:0] exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    logic [7:0] b;
    int         c = 0;
    ready_i = 1'b0;
    pkt = '{8'hA5, 8'h00, 8'h08, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt);
    while (!(state_o == 3'd6 && valid_o) && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    n_vec++;
    if (state_o !== 3'd6 || valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL send_stall_reach: state=%0d valid=%b, required 6 1", state_o, valid_o);
    end
    pulse_reset("send");
    ready_i = 1'b1;
    got.delete();
    pkt = '{8'hA5, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_pkt(pkt);
    wait_out(4);
    n_vec++;
    if (got.size() !== 4) begin n_err++; $display("FAIL send_rst_count: %0d bytes, required 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      b = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (b !== exp[i]) begin n_err++; $display("FAIL send_rst_byte%0d: %02h, required %02h", i, b, exp[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_i = 1'b0;
    data_i = 8'h00;
    ready_i = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_add;
    test_mul;
    test_xor;
    test_echo;
    test_echo_hdr_only;
    test_bad_len;
    test_unknown_op;
    test_short_len;
    test_rst_mid_accum;
    test_rst_mid_send;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
